spi_cmd_writer: RTL and testbench

Command parser and write engine between the SPI slave and the two display memory banks. It consumes 16-bit words the SPI slave has already brought into the `clk` domain and decodes them into framed commands: pixel block write, rectangular-free fill, and brightness set. It drives the shared 11-bit memory write port, where bit 10 selects the upper or lower bank. It also exports a brightness limit to the scan/decode logic.

---
 rtl/ledz_pkg.sv | 21 ++
 rtl/spi_cmd_writer_if.sv | 26 ++
 rtl/word_fifo.sv | 47 ++++
 rtl/spi_cmd_writer.sv | 182 ++++++++++++++++++
 tb/tb_spi_cmd_writer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ledz_pkg.sv
// Shared opcodes, parser states and panel geometry for the display write path.
`timescale 1ns/1ps
package ledz_pkg;

   localparam int ROWLEN = 64;

   localparam logic [3:0] OP_NOP    = 4'h0;
   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [3:0] OP_FILL   = 4'h2;
   localparam logic [3:0] OP_BRIGHT = 4'h4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DATA,
      ST_FILLVAL,
      ST_FILL,
      ST_DISCARD
   } state_t;

endpackage

// File: rtl/spi_cmd_writer_if.sv
// Word input from the SPI slave plus the memory write port and status outputs.
`timescale 1ns/1ps
interface spi_cmd_writer_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              frame_end;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [5:0]        brightness;
   logic              busy;
   logic [7:0]        err_count;

   modport slave (
      input  in_valid, in_data, frame_end,
      output mem_wen, mem_addr, mem_wdata, brightness, busy, err_count
   );

   modport master (
      output in_valid, in_data, frame_end,
      input  mem_wen, mem_addr, mem_wdata, brightness, busy, err_count
   );
endinterface

// File: rtl/word_fifo.sv
// Show-ahead synchronous FIFO; a pop in the same cycle frees room for a push when full.
`timescale 1ns/1ps
module word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;
   logic             do_pop;
   logic             do_push;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                    (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr_reg[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[PTR_W-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end
endmodule

// File: rtl/spi_cmd_writer.sv
// Parses framed SPI command words and drives the banked display memory write port.
`timescale 1ns/1ps
module spi_cmd_writer
   import ledz_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_cmd_writer_if.slave bus
);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [CNT_W-1:0]  remaining_reg, remaining_next;
   logic              fill_mode_reg, fill_mode_next;
   logic [DATA_W-1:0] fill_color_reg, fill_color_next;
   logic              mem_wen_reg, mem_wen_next;
   logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
   logic [5:0]        brightness_reg, brightness_next;
   logic [7:0]        err_count_reg, err_count_next;
   logic              end_pending_reg, end_pending_next;

   logic              fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic [3:0]        opcode;
   logic [CNT_W-1:0]  count_raw, count_clamped;
   logic              drop, abort, fsm_err, do_write;
   logic [DATA_W-1:0] write_data;
   logic [8:0]        err_sum;

   word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid),
      .din   (bus.in_data),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   assign opcode        = fifo_dout[DATA_W-1:DATA_W-4];
   assign count_raw     = fifo_dout[CNT_W-1:0];
   assign count_clamped = (count_raw == '0 || count_raw > MAX_CNT) ? MAX_CNT : count_raw;
   assign drop          = bus.in_valid & fifo_full & ~fifo_pop;
   // A frame end waits for buffered words to drain and never cuts a fill short.
   assign abort         = end_pending_reg && fifo_empty && (state_reg != ST_FILL);

   always_comb begin
      state_next       = state_reg;
      addr_next        = addr_reg;
      remaining_next   = remaining_reg;
      fill_mode_next   = fill_mode_reg;
      fill_color_next  = fill_color_reg;
      mem_wen_next     = 1'b0;
      mem_addr_next    = mem_addr_reg;
      mem_wdata_next   = mem_wdata_reg;
      brightness_next  = brightness_reg;
      fifo_pop         = 1'b0;
      fsm_err          = 1'b0;
      do_write         = 1'b0;
      write_data       = fifo_dout;
      end_pending_next = bus.frame_end | (end_pending_reg & ~abort);

      if (abort) begin
         state_next = ST_IDLE;
         fsm_err    = (state_reg == ST_COUNT) || (state_reg == ST_DATA) ||
                      (state_reg == ST_FILLVAL);
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  addr_next = fifo_dout[ADDR_W-1:0];
                  case (opcode)
                     OP_NOP: ;
                     OP_WRITE: begin
                        fill_mode_next = 1'b0;
                        state_next     = ST_COUNT;
                     end
                     OP_FILL: begin
                        fill_mode_next = 1'b1;
                        state_next     = ST_COUNT;
                     end
                     OP_BRIGHT: brightness_next = fifo_dout[5:0];
                     default: begin
                        fsm_err    = 1'b1;
                        state_next = ST_DISCARD;
                     end
                  endcase
               end
            end
            ST_COUNT: begin
               if (!fifo_empty) begin
                  fifo_pop       = 1'b1;
                  remaining_next = count_clamped;
                  state_next     = fill_mode_reg ? ST_FILLVAL : ST_DATA;
               end
            end
            ST_DATA: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  do_write = 1'b1;
                  if (remaining_reg == ONE_CNT) state_next = ST_IDLE;
               end
            end
            ST_FILLVAL: begin
               // The colour word itself produces the first fill write.
               if (!fifo_empty) begin
                  fifo_pop        = 1'b1;
                  fill_color_next = fifo_dout;
                  do_write        = 1'b1;
                  state_next      = (remaining_reg == ONE_CNT) ? ST_IDLE : ST_FILL;
               end
            end
            ST_FILL: begin
               do_write   = 1'b1;
               write_data = fill_color_reg;
               if (remaining_reg == ONE_CNT) state_next = ST_IDLE;
            end
            ST_DISCARD: begin
               if (!fifo_empty) fifo_pop = 1'b1;
            end
            default: state_next = ST_IDLE;
         endcase
      end

      if (do_write) begin
         mem_wen_next   = 1'b1;
         mem_addr_next  = addr_reg;
         mem_wdata_next = write_data;
         addr_next      = addr_reg + 1'b1;
         remaining_next = remaining_reg - 1'b1;
      end

      // Overflow drop and parser error can land in the same cycle.
      err_sum        = {1'b0, err_count_reg} + {8'd0, drop} + {8'd0, fsm_err};
      err_count_next = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         addr_reg        <= '0;
         remaining_reg   <= '0;
         fill_mode_reg   <= 1'b0;
         fill_color_reg  <= '0;
         mem_wen_reg     <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         brightness_reg  <= 6'd63;
         err_count_reg   <= '0;
         end_pending_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         addr_reg        <= addr_next;
         remaining_reg   <= remaining_next;
         fill_mode_reg   <= fill_mode_next;
         fill_color_reg  <= fill_color_next;
         mem_wen_reg     <= mem_wen_next;
         mem_addr_reg    <= mem_addr_next;
         mem_wdata_reg   <= mem_wdata_next;
         brightness_reg  <= brightness_next;
         err_count_reg   <= err_count_next;
         end_pending_reg <= end_pending_next;
      end
   end

   assign bus.mem_wen    = mem_wen_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.mem_wdata  = mem_wdata_reg;
   assign bus.brightness = brightness_reg;
   assign bus.err_count  = err_count_reg;
   assign bus.busy       = (state_reg != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_spi_cmd_writer.sv
// Directed command frames; expected memory writes are queued and checked by a write monitor.
`timescale 1ns/1ps
module tb_spi_cmd_writer;
   import ledz_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_cmd_writer_if bus();

   spi_cmd_writer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  check_cnt = 0;
   int  pass_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      check_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Write monitor: every memory write must match the oldest expected write.
   always @(negedge clk) begin : mon
      wr_t e;
      if (rst_n && bus.mem_wen) begin
         if (exp_q.size() == 0) begin
            check_cnt++;
            $display("FAIL wr_unexpected: got addr %03h data %04h, required no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr", {5'd0, bus.mem_addr, bus.mem_wdata}, {5'd0, e.addr, e.data});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_end();
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((bus.busy || bus.mem_wen) && n < max_cycles) begin
         tick();
         n++;
      end
      chk("idle_timeout", {30'd0, bus.busy, bus.mem_wen}, 32'd0);
   endtask

   task automatic expect_wr(input logic [10:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.frame_end = 1'b0;
      repeat (3) tick();

      $display("reset state");
      chk("rst_wen", bus.mem_wen, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_bright", bus.brightness, 63);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err_count, 0);
      rst_n = 1'b1;
      tick();

      $display("WRITE 3 words at row 1");
      for (int i = 0; i < 3; i++) expect_wr(11'(ROWLEN + i), 16'h00A1 + 16'(i));
      send(16'h1040); send(16'h0003);
      send(16'h00A1); send(16'h00A2); send(16'h00A3);
      wait_idle(50);
      chk("wr_busy", bus.busy, 0);
      chk("wr_err", bus.err_count, 0);

      $display("FILL 4 words wrapping at 0x7FF");
      expect_wr(11'h7FE, 16'hF800); expect_wr(11'h7FF, 16'hF800);
      expect_wr(11'h000, 16'hF800); expect_wr(11'h001, 16'hF800);
      send(16'h27FE); send(16'h0004); send(16'hF800);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fill_run", bus.mem_wen, 1);
      end
      tick();
      chk("fill_stop", bus.mem_wen, 0);
      wait_idle(50);

      $display("BRIGHT 32 then bad opcode frame");
      send(16'h4020);
      wait_idle(50);
      chk("bright32", bus.brightness, 32);
      send(16'h9000); send(16'h1111); send(16'h2222);
      pulse_end();
      wait_idle(50);
      chk("badop_err", bus.err_count, 1);

      $display("truncated WRITE then BRIGHT 16");
      expect_wr(11'h000, 16'hD001); expect_wr(11'h001, 16'hD002);
      send(16'h1000); send(16'h0005); send(16'hD001); send(16'hD002);
      pulse_end();
      wait_idle(50);
      chk("trunc_err", bus.err_count, 2);
      send(16'h4010);
      wait_idle(50);
      chk("bright16", bus.brightness, 16);

      $display("FILL 2048 with clamped count and FIFO overflow");
      for (int i = 0; i < 2048; i++) expect_wr(11'(i), 16'h07E0);
      send(16'h2000); send(16'h0FFF); send(16'h07E0);
      repeat (3) tick();
      send(16'h4005); send(16'h0000); send(16'h4007); send(16'h0000);
      send(16'h4001); send(16'h4002);
      chk("ovf_err", bus.err_count, 4);
      chk("ovf_bright_hold", bus.brightness, 16);
      wait_idle(3000);
      chk("ovf_bright", bus.brightness, 7);
      chk("ovf_err_end", bus.err_count, 4);

      $display("reset during FILL");
      for (int i = 0; i < 9; i++) expect_wr(11'h100 + 11'(i), 16'h5555);
      send(16'h2100); send(16'h0000); send(16'h5555);
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_wen", bus.mem_wen, 0);
      chk("arst_addr", bus.mem_addr, 0);
      chk("arst_wdata", bus.mem_wdata, 0);
      chk("arst_bright", bus.brightness, 63);
      chk("arst_err", bus.err_count, 0);
      chk("arst_busy", bus.busy, 0);
      repeat (3) tick();
      chk("arst_hold_wen", bus.mem_wen, 0);
      chk("arst_sb", exp_q.size(), 0);
      rst_n = 1'b1;
      tick();

      $display("WRITE 1 word after reset");
      expect_wr(11'h100, 16'h1234);
      send(16'h1100); send(16'h0001); send(16'h1234);
      tick();
      chk("lat_wen", bus.mem_wen, 1);
      chk("lat_addr", bus.mem_addr, 32'h100);
      chk("lat_data", bus.mem_wdata, 32'h1234);
      tick();
      chk("lat_single", bus.mem_wen, 0);
      wait_idle(50);
      tick();
      chk("final_err", bus.err_count, 0);
      chk("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
